hes_msg_feeder: RTL and testbench
=================================

# hes_msg_feeder

Upstream input stage of the HES hash datapath. It accepts message bytes from the host over a valid/ready stream and buffers them in a small FIFO. It presents them to the hash control/datapath through the `F_dr`/`F_rtr` handshake. It also generates the `End_of_File` pulse and the `case_rc0` empty-message qualifier that the control stage consumes. One message is in flight at a time, framed by `start`.

## Interface
Parameters:
- `DEPTH`, 4: FIFO entries. Must be a power of two, ≥ 2.
- `LEN_W`, 16: width of the delivered-byte counter.

Ports:
- `clk`, in, 1: clock.
- `rst_n`, in, 1: reset, asynchronous, active-low.
- `start`, in, 1: begin a new message. Shared with the control stage.
- `in_valid`, in, 1: host byte valid.
- `in_ready`, out, 1: feeder can accept a host entry.
- `in_data`, in, 8: message byte.
- `in_last`, in, 1: this entry closes the message.
- `in_empty`, in, 1: with `in_last`, the entry carries no byte (zero-length message). Ignored if `in_last`=0.
- `F_dr`, out, 1: `data_out` holds a valid byte.
- `F_rtr`, in, 1: downstream ready to read.
- `data_out`, out, 8: byte at the FIFO head.
- `End_of_File`, out, 1: single-cycle end-of-message pulse.
- `case_rc0`, out, 1: no byte of the current message delivered yet.
- `msg_len`, out, LEN_W: bytes delivered in the current message. Saturates.

## Operation
- State machine `IDLE`, `STREAM`, `EOFP`, `DONE`. Reset puts it in `IDLE`.
- Transitions:
  - `IDLE`/`DONE` + `start` → `STREAM`.
  - `STREAM`: when the head entry is a last entry and is retired → `EOFP`.
  - `EOFP` → `DONE` unconditionally.
- `start` in `STREAM`/`EOFP` aborts the message:
  - FIFO flushed, counter cleared, `last_seen` cleared.
  - Next state is `STREAM`.
  - A same-cycle host entry is dropped.
- FIFO entry is {`last`, `empty`, `data`}.
- Push when `in_valid & in_ready`. `in_ready` = `state==STREAM & !full & !last_seen`.
- `last_seen` sets on a pushed `in_last` entry. It clears on `start` or reset. This gives one message per `start`.
- `F_dr` = `state==STREAM` & FIFO not empty & head `empty`=0.
- A head byte is delivered when `F_dr & F_rtr`. That pops it and increments `msg_len`, saturating at 2^LEN_W−1.
- A head entry with `empty`=1 is popped in `STREAM` without `F_dr` or `F_rtr`. That retire also moves the state to `EOFP`.
- `End_of_File` = `state==EOFP`.
- `case_rc0` = (`msg_len`==0). Valid in every state, so `case_rc0 & End_of_File` flags a zero-length message.
- `data_out` shows the head data whenever the FIFO is non-empty. It is a don't-care otherwise; the bench must not check it then.
- Push and pop may happen in the same cycle when the FIFO is neither full nor empty. When full, `in_ready`=0 even if a pop happens that cycle.

## Timing
- Reset values:
  - Outputs: `in_ready`=0, `F_dr`=0, `data_out`=0, `End_of_File`=0, `case_rc0`=1, `msg_len`=0.
  - Internal: FIFO empty, `last_seen`=0.
- Fill latency: a byte pushed at edge t is presented with `F_dr`=1 from cycle t+1. Storage is registered, with no combinational input→output path.
- `End_of_File` asserts in the cycle after the edge that retires the last entry, for exactly one cycle.
- `in_ready` rises one cycle after `start`.
- `msg_len`/`case_rc0` update on the edge of the delivering handshake.
- Asynchronous reset mid-message discards everything. `start` takes priority over push, pop and state transitions.

## Structure
- `hes_pkg` holds:
  - `feeder_state_t` enum.
  - `BYTE_W`=8.
  - Entry struct `feed_entry_t` {`last`, `empty`, `data`}.
- Sub-module `hes_byte_fifo`: parametric synchronous FIFO of `feed_entry_t` with `push`, `pop`, `flush`, `full`, `empty` and head output. It is instantiated once here.

## Test plan
- Reset, then `start`, then push 0xA1, 0xB2, 0xC3 (last) with `F_rtr`=1 → bytes out in order, `msg_len`=3, one `End_of_File` pulse with `case_rc0`=0.
- `start`, then push one entry with `in_last`=1, `in_empty`=1 → `F_dr` never asserts, `End_of_File`=1 with `case_rc0`=1.
- `F_rtr`=0 while 5 bytes are offered (DEPTH=4) → `in_ready` drops after 4 accepts. Raising `F_rtr` drains 0..4 in order with no loss.
- After the last entry is accepted, host holds `in_valid`=1 → `in_ready` stays 0 until the next `start`.
- `start` mid-message with 2 bytes buffered → FIFO flushed, `msg_len`=0, no `End_of_File`, a new message streams correctly.
- Deliver 2^LEN_W+1 bytes with LEN_W=4 → `msg_len` saturates at 15.

Source files
------------

// File: rtl/hes_pkg.sv
// Shared types for the HES hash input stage: feeder FSM states and FIFO entry layout.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package hes_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        EOFP   = 2'd2,
        DONE   = 2'd3
    } feeder_state_t;

    // One buffered host entry; empty=1 marks a byte-less terminator (zero-length message)
    typedef struct packed {
        logic              last;
        logic              empty;
        logic [BYTE_W-1:0] data;
    } feed_entry_t;

endpackage

// File: rtl/hes_byte_fifo.sv
// Synchronous FIFO of feed_entry_t with flush; head entry is visible combinationally from storage.
// Latency: an entry pushed at edge t is at the head from cycle t+1 (registered storage only).
// Backpressure: push ignored when full, pop ignored when empty; flush wins over push and pop.
module hes_byte_fifo
    import hes_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic        flush,
    input  feed_entry_t wr_entry,
    output feed_entry_t head,
    output logic        full,
    output logic        empty
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    feed_entry_t       mem_q [DEPTH];
    feed_entry_t       mem_d [DEPTH];
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic              do_push, do_pop;

    // Status flags use the extra pointer bit to tell full from empty
    always_comb begin
        empty   = (wr_ptr_q == rd_ptr_q);
        full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        head    = mem_q[rd_ptr_q[AW-1:0]];
        do_push = push && !full;
        do_pop  = pop && !empty;
    end

    // Pointer and storage next-state; flush only rewinds pointers, stale data is never exposed as valid
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q[AW-1:0]] = wr_entry;
                wr_ptr_d                = wr_ptr_q + (AW+1)'(1);
            end
            if (do_pop) begin
                rd_ptr_d = rd_ptr_q + (AW+1)'(1);
            end
        end
    end

    // Storage and pointer registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            mem_q    <= mem_d;
        end
    end

endmodule

// File: rtl/hes_msg_feeder.sv
// Host byte stream to hash datapath feeder: buffers one start-framed message, emits End_of_File and case_rc0.
// Latency: byte accepted at edge t is offered with F_dr from cycle t+1; End_of_File one cycle after last retire.
// Backpressure: in_ready drops when FIFO full or the message's last entry was taken; F_rtr stalls the head.
module hes_msg_feeder
    import hes_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int LEN_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [BYTE_W-1:0] in_data,
    input  logic              in_last,
    input  logic              in_empty,
    output logic              F_dr,
    input  logic              F_rtr,
    output logic [BYTE_W-1:0] data_out,
    output logic              End_of_File,
    output logic              case_rc0,
    output logic [LEN_W-1:0]  msg_len
);

    feeder_state_t     state_q, state_d;
    logic              last_seen_q, last_seen_d;
    logic [LEN_W-1:0]  msg_len_q, msg_len_d;

    feed_entry_t       wr_entry;
    feed_entry_t       head;
    logic              fifo_full, fifo_empty;
    logic              push, pop, deliver, retire_empty;

    hes_byte_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (push),
        .pop      (pop),
        .flush    (start),
        .wr_entry (wr_entry),
        .head     (head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // Handshake decode; start suppresses every push and pop in its cycle
    always_comb begin
        in_ready       = (state_q == STREAM) && !fifo_full && !last_seen_q;
        F_dr           = (state_q == STREAM) && !fifo_empty && !head.empty;
        deliver        = F_dr && F_rtr && !start;
        retire_empty   = (state_q == STREAM) && !fifo_empty && head.empty && !start;
        pop            = deliver || retire_empty;
        push           = in_valid && in_ready && !start;
        wr_entry.last  = in_last;
        wr_entry.empty = in_last && in_empty;
        wr_entry.data  = in_data;
    end

    // Message FSM, last_seen gate and saturating delivered-byte counter
    always_comb begin
        state_d     = state_q;
        last_seen_d = last_seen_q;
        msg_len_d   = msg_len_q;
        if (start) begin
            state_d     = STREAM;
            last_seen_d = 1'b0;
            msg_len_d   = '0;
        end else begin
            if (push && in_last) begin
                last_seen_d = 1'b1;
            end
            if (deliver && (msg_len_q != '1)) begin
                msg_len_d = msg_len_q + LEN_W'(1);
            end
            case (state_q)
                STREAM:  if (pop && head.last) state_d = EOFP;
                EOFP:    state_d = DONE;
                default: state_d = state_q;
            endcase
        end
    end

    // Control state registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            last_seen_q <= 1'b0;
            msg_len_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_seen_q <= last_seen_d;
            msg_len_q   <= msg_len_d;
        end
    end

    // Output decode
    always_comb begin
        data_out    = head.data;
        End_of_File = (state_q == EOFP);
        case_rc0    = (msg_len_q == '0);
        msg_len     = msg_len_q;
    end

endmodule

// File: tb/tb_hes_msg_feeder.sv
module tb_hes_msg_feeder;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_last = 1'b0;
    logic       in_empty = 1'b0;
    logic       F_rtr = 1'b0;
    logic [7:0] in_data = 8'h00;
    logic       in_ready;
    logic       F_dr;
    logic       End_of_File;
    logic       case_rc0;
    logic [7:0] data_out;
    logic [3:0] msg_len;

    int         checks = 0;
    int         errors = 0;
    logic [7:0] exp_q [$];
    logic [4:0] eof_q [$];
    int         msg_bytes = 0;
    logic       prev_eof = 1'b0;
    logic [4:0] eof_exp;
    logic [7:0] byte_exp;

    always #5 clk = ~clk;

    hes_msg_feeder #(
        .DEPTH (4),
        .LEN_W (4)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .in_empty    (in_empty),
        .F_dr        (F_dr),
        .F_rtr       (F_rtr),
        .data_out    (data_out),
        .End_of_File (End_of_File),
        .case_rc0    (case_rc0),
        .msg_len     (msg_len)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_start();
        start = 1'b1;
        tick();
        start = 1'b0;
        exp_q.delete();
        msg_bytes = 0;
    endtask

    // Offer one entry until accepted; record what the DUT must later produce
    task automatic push_entry(input logic [7:0] d, input logic l, input logic e);
        int  n;
        logic ok;
        n  = 0;
        ok = 1'b0;
        in_valid = 1'b1;
        in_data  = d;
        in_last  = l;
        in_empty = e;
        do begin
            @(negedge clk);
            ok = in_ready;
            tick();
            n++;
        end while (!ok && n < 50);
        in_valid = 1'b0;
        in_last  = 1'b0;
        in_empty = 1'b0;
        if (!ok) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: got in_ready 0 expected 1 for byte %0h", d);
        end else begin
            if (!(l && e)) begin
                exp_q.push_back(d);
                msg_bytes++;
            end
            if (l) begin
                eof_q.push_back({(msg_bytes == 0), (msg_bytes > 15) ? 4'd15 : 4'(msg_bytes)});
            end
        end
    endtask

    task automatic wait_eof();
        int n;
        n = 0;
        while (eof_q.size() != 0 && n < 100) begin
            tick();
            n++;
        end
        if (eof_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL eof_timeout: got no End_of_File expected pulse");
            eof_q.delete();
        end
    endtask

    // Monitor: compares delivered bytes and End_of_File pulses against the scoreboard queues
    always @(negedge clk) begin
        if (rst_n) begin
            if (prev_eof) chk("eof_one_cycle", End_of_File, 0);
            prev_eof = End_of_File;
            if (End_of_File) begin
                if (eof_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_eof: got 1 expected 0");
                end else begin
                    eof_exp = eof_q.pop_front();
                    chk("eof_case_rc0", case_rc0, eof_exp[4]);
                    chk("eof_msg_len", msg_len, eof_exp[3:0]);
                end
            end
            if (F_dr && F_rtr && !start) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_byte: got %0h expected none", data_out);
                end else begin
                    byte_exp = exp_q.pop_front();
                    chk("data_out", data_out, byte_exp);
                end
            end else if (F_dr && exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_f_dr: got 1 expected 0");
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_f_dr", F_dr, 0);
        chk("rst_data_out", data_out, 8'h00);
        chk("rst_eof", End_of_File, 0);
        chk("rst_case_rc0", case_rc0, 1);
        chk("rst_msg_len", msg_len, 0);
        tick();
        rst_n = 1'b1;
        tick();
        chk("idle_in_ready", in_ready, 0);

        // Three-byte message, downstream always ready
        F_rtr = 1'b1;
        do_start();
        chk("in_ready_after_start", in_ready, 1);
        push_entry(8'hA1, 1'b0, 1'b0);
        push_entry(8'hB2, 1'b0, 1'b0);
        push_entry(8'hC3, 1'b1, 1'b0);
        wait_eof();
        tick();
        tick();
        chk("done_in_ready", in_ready, 0);
        chk("done_msg_len", msg_len, 3);

        // Zero-length message
        do_start();
        push_entry(8'h00, 1'b1, 1'b1);
        wait_eof();
        tick();

        // Backpressure: fill to DEPTH with F_rtr low, then drain
        F_rtr = 1'b0;
        do_start();
        push_entry(8'h00, 1'b0, 1'b0);
        chk("fill_latency_f_dr", F_dr, 1);
        chk("fill_latency_data", data_out, 8'h00);
        push_entry(8'h01, 1'b0, 1'b0);
        push_entry(8'h02, 1'b0, 1'b0);
        push_entry(8'h03, 1'b0, 1'b0);
        in_valid = 1'b1;
        in_data  = 8'h04;
        in_last  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("full_in_ready", in_ready, 0);
            tick();
        end
        F_rtr = 1'b1;
        push_entry(8'h04, 1'b1, 1'b0);

        // Host keeps offering after the last entry: must stay blocked
        in_valid = 1'b1;
        in_data  = 8'h55;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk("after_last_in_ready", in_ready, 0);
        end
        tick();
        in_valid = 1'b0;
        wait_eof();

        // Abort mid-message with bytes buffered, then a fresh message
        do_start();
        push_entry(8'h11, 1'b0, 1'b0);
        tick();
        F_rtr = 1'b0;
        push_entry(8'h22, 1'b0, 1'b0);
        push_entry(8'h33, 1'b0, 1'b0);
        chk("pre_abort_msg_len", msg_len, 1);
        chk("pre_abort_case_rc0", case_rc0, 0);
        chk("pre_abort_head", data_out, 8'h22);
        in_valid = 1'b1;
        in_data  = 8'h99;
        do_start();
        in_valid = 1'b0;
        chk("abort_msg_len", msg_len, 0);
        chk("abort_case_rc0", case_rc0, 1);
        chk("abort_f_dr", F_dr, 0);
        chk("abort_in_ready", in_ready, 1);
        tick();
        chk("abort_drop_f_dr", F_dr, 0);
        F_rtr = 1'b1;
        push_entry(8'h44, 1'b0, 1'b0);
        push_entry(8'h55, 1'b1, 1'b0);
        wait_eof();
        tick();

        // Counter saturation: 17 bytes with a 4-bit counter
        do_start();
        for (int i = 1; i <= 17; i++) begin
            push_entry(8'(i), (i == 17), 1'b0);
        end
        wait_eof();
        tick();
        chk("sat_msg_len", msg_len, 15);

        tick();
        chk("exp_q_drained", exp_q.size(), 0);
        chk("eof_q_drained", eof_q.size(), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
